uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, giving baud_tick pulses per bit period.
REQ-003 SHALL have port wclk, input, 1 bit: clock, which is also the RX FIFO write clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port baud_tick, input, 1 bit: one-wclk pulse at OVERSAMPLE times the baud rate.
REQ-006 SHALL have port rxd, input, 1 bit: serial line, asynchronous to wclk, idle high.
REQ-007 SHALL have port parity_en, input, 1 bit: 1 means a parity bit follows the data bits.
REQ-008 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-009 SHALL have port stop2, input, 1 bit: 1 means two stop bits are checked.
REQ-010 SHALL have port fifo_full, input, 1 bit: full flag of the RX FIFO.
REQ-011 SHALL have port rx_data, output, DATA_WIDTH bits: received word, valid while rx_wr is high.
REQ-012 SHALL have port rx_wr, output, 1 bit: one-cycle RX FIFO write strobe.
REQ-013 SHALL have port parity_err, output, 1 bit: one-cycle pulse flagging a parity mismatch.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse flagging a stop bit sampled as 0.
REQ-015 SHALL have port overrun_err, output, 1 bit: one-cycle pulse flagging a word dropped because the FIFO was full.
REQ-016 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL pass rxd through a 2-flop synchronizer (output rxd_s) before any use; its flops reset to 1.
REQ-018 SHALL use the states IDLE, START, DATA, PARITY, STOP1 and STOP2.
REQ-019 SHALL advance the tick counter and the state only on wclk cycles where baud_tick=1.
REQ-020 SHALL move from IDLE to START, with the tick counter cleared, on a baud_tick where rxd_s=0.
REQ-021 SHALL, in START, sample rxd_s at tick OVERSAMPLE/2-1 (mid-bit): 1 returns to IDLE (false start, no outputs); 0 goes to DATA.
REQ-022 SHALL, in DATA, sample every OVERSAMPLE ticks from the start mid-point, shifting LSB first, for DATA_WIDTH bits.
REQ-023 SHALL go to PARITY when parity_en=1 and to STOP1 otherwise.
REQ-024 SHALL flag a parity error when the XOR of the data bits and the parity bit is not equal to parity_odd.
REQ-025 SHALL go from STOP1 to STOP2 when stop2=1 at the STOP1 mid-sample.
REQ-026 SHALL flag a frame error when any checked stop bit samples as 0.
REQ-027 SHALL complete a frame at the mid-sample of the final stop bit and, on the next wclk cycle, assert rx_wr for exactly one cycle with rx_data valid, provided fifo_full=0.
REQ-028 SHALL, when fifo_full=1 at completion, hold rx_wr=0, pulse overrun_err for one cycle and discard the word.
REQ-029 SHALL pulse parity_err and frame_err in the completion cycle; the word is still written (or dropped per REQ-028).
REQ-030 SHALL return to IDLE at completion so that a start edge half a bit later is accepted.
REQ-031 SHALL sample parity_en, parity_odd and stop2 once, on the IDLE-to-START transition, and hold them for the whole frame.
REQ-032 SHALL keep rx_data stable between writes.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, counters=0, rx_data=0, and rx_wr, parity_err, frame_err, overrun_err and rx_busy to 0.
REQ-034 SHALL abandon any partial frame on reset mid-frame, with no write after release.

Structure
REQ-035 SHALL place the state enum and the OVERSAMPLE default in the shared package uart_pkg.
REQ-036 SHALL instantiate the sub-module uart_sync for the 2-flop synchronizer.

Verification
REQ-037 Bench SHALL check: 8N1 frame of 0x55 -> exactly one rx_wr, rx_data=0x55, all error outputs 0.
REQ-038 Bench SHALL check: even-parity frame of 0xA3 with parity bit 1 -> rx_wr with rx_data=0xA3 and parity_err=1.
REQ-039 Bench SHALL check: frame of 0x3C with stop bit 0 -> rx_wr with rx_data=0x3C and frame_err=1.
REQ-040 Bench SHALL check: frame of 0x7E with fifo_full=1 -> rx_wr=0 and a single overrun_err pulse.
REQ-041 Bench SHALL check: rxd low for 4 ticks only -> no rx_wr, rx_busy back to 0 at tick 7.
REQ-042 Bench SHALL check: rst_n pulsed during the 3rd data bit -> all outputs 0, no write, next frame 0xC1 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and defaults: frame state encoding and oversampling rate.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops idle high.
module uart_sync (
  input  logic wclk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, one or two stop bits,
// one-cycle FIFO write strobe with parity, framing and overrun flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  rxd,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_full,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_wr,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  rx_busy
);

  localparam int CNT_W = cnt_width(OVERSAMPLE);
  localparam int BIT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  logic rxd_s;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       tick_q, tick_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   par_en_q, par_en_d;
  logic                   par_odd_q, par_odd_d;
  logic                   stop2_q, stop2_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_wr_q, rx_wr_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   complete;

  uart_sync u_sync (
    .wclk  (wclk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      stop2_q       <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_wr_q       <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_en_q      <= par_en_d;
      par_odd_q     <= par_odd_d;
      stop2_q       <= stop2_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
      rx_data_q     <= rx_data_d;
      rx_wr_q       <= rx_wr_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    par_en_d      = par_en_q;
    par_odd_d     = par_odd_q;
    stop2_d       = stop2_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    rx_data_d     = rx_data_q;
    rx_wr_d       = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    complete      = 1'b0;

    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          // Line configuration is frozen here so a mid-frame change cannot corrupt the frame.
          if (!rxd_s) begin
            state_d   = START;
            tick_d    = '0;
            bit_d     = '0;
            par_en_d  = parity_en;
            par_odd_d = parity_odd;
            stop2_d   = stop2;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
          end
        end
        START: begin
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == FULL_TICK) begin
            tick_d  = '0;
            shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LAST_BIT) begin
              state_d = par_en_q ? PARITY : STOP1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_q == FULL_TICK) begin
            tick_d  = '0;
            perr_d  = ((^shift_q) ^ rxd_s) != par_odd_q;
            state_d = STOP1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP1: begin
          if (tick_q == FULL_TICK) begin
            tick_d = '0;
            ferr_d = ferr_q | ~rxd_s;
            if (stop2_q) begin
              state_d = STOP2;
            end else begin
              complete = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP2: begin
          if (tick_q == FULL_TICK) begin
            tick_d   = '0;
            ferr_d   = ferr_q | ~rxd_s;
            complete = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end

    // Back to IDLE at the final stop mid-sample so a start edge half a bit later is caught.
    if (complete) begin
      state_d       = IDLE;
      rx_wr_d       = ~fifo_full;
      overrun_err_d = fifo_full;
      parity_err_d  = perr_q;
      frame_err_d   = ferr_d;
      if (!fifo_full) begin
        rx_data_d = shift_q;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_wr       = rx_wr_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: hand-built frames on rxd, pulse counts observed per frame.
module tb_uart_rx_core;

  logic       wclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop2 = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_wr;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rx_busy;

  int check_cnt = 0;
  int error_cnt = 0;

  // Cycle-level pulse counters, written only by the monitor below.
  int         wr_cycles = 0;
  int         perr_cycles = 0;
  int         ferr_cycles = 0;
  int         ovr_cycles = 0;
  logic [7:0] last_data = 8'h00;

  int base_wr, base_perr, base_ferr, base_ovr;

  uart_rx_core #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .wclk        (wclk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .stop2       (stop2),
    .fifo_full   (fifo_full),
    .rx_data     (rx_data),
    .rx_wr       (rx_wr),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (rx_wr) begin
      wr_cycles++;
      last_data = rx_data;
    end
    if (parity_err)  perr_cycles++;
    if (frame_err)   ferr_cycles++;
    if (overrun_err) ovr_cycles++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Two quiet cycles let a new rxd level clear the synchronizer before the tick.
  task automatic do_tick();
    @(negedge wclk);
    @(negedge wclk);
    baud_tick = 1'b1;
    @(negedge wclk);
    baud_tick = 1'b0;
  endtask

  task automatic send_bit(input logic v, input int n);
    rxd = v;
    repeat (n) do_tick();
  endtask

  task automatic snapshot();
    base_wr   = wr_cycles;
    base_perr = perr_cycles;
    base_ferr = ferr_cycles;
    base_ovr  = ovr_cycles;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_a, input logic two_stop, input logic stop_b);
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) send_bit(d[i], 16);
    if (par_on) send_bit(par_bit, 16);
    send_bit(stop_a, 16);
    if (two_stop) send_bit(stop_b, 16);
    send_bit(1'b1, 24);
  endtask

  task automatic check_frame(input string tag, input int wr, input logic [7:0] data,
                             input int perr, input int ferr, input int ovr);
    check_val({tag, "_wr"},   32'(wr_cycles - base_wr), 32'(wr));
    check_val({tag, "_data"}, {24'h0, last_data}, {24'h0, data});
    check_val({tag, "_perr"}, 32'(perr_cycles - base_perr), 32'(perr));
    check_val({tag, "_ferr"}, 32'(ferr_cycles - base_ferr), 32'(ferr));
    check_val({tag, "_ovr"},  32'(ovr_cycles - base_ovr), 32'(ovr));
    check_val({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge wclk);
    check_val("rst_wr",   {31'h0, rx_wr}, 32'h0);
    check_val("rst_busy", {31'h0, rx_busy}, 32'h0);
    check_val("rst_data", {24'h0, rx_data}, 32'h0);
    check_val("rst_errs", {29'h0, parity_err, frame_err, overrun_err}, 32'h0);
    rst_n = 1'b1;
    send_bit(1'b1, 4);

    // 8N1, 0x55
    snapshot();
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frame("8n1_55", 1, 8'h55, 0, 0, 0);

    // Even parity, 0xA3 has four ones so parity bit 1 is wrong
    parity_en = 1'b1; parity_odd = 1'b0;
    snapshot();
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frame("even_a3", 1, 8'hA3, 1, 0, 0);

    // Odd parity, same bit 1 is correct
    parity_odd = 1'b1;
    snapshot();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_frame("odd_5a", 1, 8'h5A, 0, 0, 0);
    parity_en = 1'b0; parity_odd = 1'b0;

    // Stop bit sampled low
    snapshot();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_frame("stop0_3c", 1, 8'h3C, 0, 1, 0);

    // FIFO full: word dropped, rx_data keeps the previous word
    fifo_full = 1'b1;
    snapshot();
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frame("full_7e", 0, 8'h3C, 0, 0, 1);
    check_val("full_7e_rxdata", {24'h0, rx_data}, 32'h3C);
    fifo_full = 1'b0;

    // Two stop bits, second one low
    stop2 = 1'b1;
    snapshot();
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("stop2_0f", 1, 8'h0F, 0, 1, 0);
    stop2 = 1'b0;

    // False start: low for 4 ticks; start is sampled on the 8th tick after detection
    snapshot();
    send_bit(1'b0, 4);
    check_val("fs_busy_early", {31'h0, rx_busy}, 32'h1);
    send_bit(1'b1, 4);
    check_val("fs_busy_before_mid", {31'h0, rx_busy}, 32'h1);
    do_tick();
    check_val("fs_busy_at_mid", {31'h0, rx_busy}, 32'h0);
    send_bit(1'b1, 20);
    check_val("fs_wr", 32'(wr_cycles - base_wr), 32'h0);

    // Reset in the middle of the third data bit of 0x55
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    send_bit(1'b1, 8);
    check_val("mid_busy_before", {31'h0, rx_busy}, 32'h1);
    @(negedge wclk);
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    check_val("mid_rst_busy", {31'h0, rx_busy}, 32'h0);
    check_val("mid_rst_data", {24'h0, rx_data}, 32'h0);
    check_val("mid_rst_wr",   {31'h0, rx_wr}, 32'h0);
    check_val("mid_rst_errs", {29'h0, parity_err, frame_err, overrun_err}, 32'h0);
    repeat (3) @(negedge wclk);
    rst_n = 1'b1;
    snapshot();
    send_bit(1'b1, 40);
    check_val("mid_after_wr",   32'(wr_cycles - base_wr), 32'h0);
    check_val("mid_after_busy", {31'h0, rx_busy}, 32'h0);

    snapshot();
    send_frame(8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_frame("after_rst_c1", 1, 8'hC1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
